riscv_trap_ctrl: RTL and testbench
==================================

Name: riscv_trap_ctrl

Overview:
- Trap/interrupt sequencer for the RISC-V core; sits between the core's decode/execute stage and the CSR file.
- Prioritises synchronous exceptions and external interrupts (masked by mie), produces the one-cycle trap pulse plus mcause that the CSR file latches into mepc/mcause, computes the redirect PC from mtvec (direct or vectored), and sequences mret return through mepc.
- Tracks handler occupancy so interrupts are not nested.

Parameters:
- IRQ_NUM, 16, number of platform interrupt lines; these map to mcause codes 16..16+IRQ_NUM-1 and mie bits 16..16+IRQ_NUM-1 (IRQ_NUM <= 16).
- MXLEN, 32, data/PC width; taken from riscv_csr_pkg.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  synchronous active-low reset
- ready_i  in  1  core is at an instruction boundary and can accept a redirect this cycle
- irq_i  in  IRQ_NUM  level-sensitive interrupt requests
- exc_illegal_i  in  1  illegal instruction (valid only with ready_i)
- exc_ecall_i  in  1  ecall (valid only with ready_i)
- exc_ebreak_i  in  1  ebreak (valid only with ready_i)
- mret_i  in  1  mret decoded (valid only with ready_i)
- mie_i  in  MXLEN  mie register from the CSR file
- mtvec_i  in  MXLEN  mtvec register from the CSR file
- mepc_i  in  MXLEN  mepc register from the CSR file
- trap_o  out  1  one-cycle pulse; the CSR file captures pc and mcause on it
- mcause_o  out  MXLEN  cause value, valid while trap_o=1
- redirect_o  out  1  one-cycle pulse; core loads redirect_pc_o
- redirect_pc_o  out  MXLEN  target PC, valid while redirect_o=1
- irq_ack_o  out  IRQ_NUM  one-hot acknowledge of the serviced interrupt, pulses with trap_o
- in_handler_o  out  1  a handler is active; interrupts are masked

Behaviour:
Reset:
- Every output is 0. FSM enters S_RUN. The cause register and the ack register are 0.

Cause selection (combinational, evaluated only when ready_i=1):
- Exceptions are checked first, in this priority: ebreak (cause 3), illegal (2), ecall (11). Interrupt bit = 0.
- If no exception: interrupt i is eligible when irq_i[i] & mie_i[16+i] & !in_handler_o.
- The lowest index i wins. Cause = 16+i with bit MXLEN-1 = 1.
- Exception and interrupt in the same cycle: the exception is taken; the interrupt stays pending because it is level-sensitive.

States:
- S_RUN: on a selected cause with ready_i=1, register the cause and go to S_TRAP. Otherwise, on mret_i with ready_i=1, go to S_MRET. With ready_i=0, nothing is sampled.
- S_TRAP (exactly 1 cycle):
  - trap_o=1, redirect_o=1, mcause_o = registered cause, irq_ack_o = registered one-hot (0 for exceptions).
  - Redirect PC: if mtvec_i[1:0]==2'b01 and the cause is an interrupt, redirect_pc_o = {mtvec_i[MXLEN-1:2],2'b00} + 4*code. Otherwise redirect_pc_o = {mtvec_i[MXLEN-1:2],2'b00}.
  - Next state: S_HANDLER.
- S_HANDLER:
  - in_handler_o=1.
  - An exception with ready_i=1 goes to S_TRAP again. This is a nested exception; mepc is overwritten and a double trap is not recoverable, by design.
  - mret_i with ready_i=1 goes to S_MRET.
  - Interrupts are ignored.
- S_MRET (exactly 1 cycle): redirect_o=1, redirect_pc_o=mepc_i, trap_o=0, in_handler_o=0. Next state: S_RUN.

Timing and edge cases:
- Latency: a cause sampled in cycle N gives trap_o/redirect_o in cycle N+1. mret sampled in cycle N gives redirect_o in cycle N+1. No back-to-back traps: at least one S_HANDLER cycle separates them.
- mret in S_RUN is legal: it redirects to mepc_i and stays out of the handler.
- mret together with an exception in the same cycle: the exception wins.
- Reset asserted in any state: next cycle is S_RUN with all outputs 0, including mid-S_TRAP.
- mcause_o and redirect_pc_o are 0 when their strobe is low.

Decomposition:
- riscv_csr_pkg holds:
  - MXLEN
  - cause constants CAUSE_ILLEGAL=2, CAUSE_EBREAK=3, CAUSE_ECALL=11, CAUSE_IRQ_BASE=16
  - MTVEC_MODE_VECTORED=2'b01
  - the typedef enum trap_state_e {S_RUN, S_TRAP, S_HANDLER, S_MRET}
- One sub-module: riscv_irq_prio. It is a parameterised lowest-index priority encoder that outputs valid, index and one-hot.

Test Plan:
- Reset: hold rstn_i=0 for 3 cycles, then release with no stimulus → all outputs 0 and in_handler_o=0 for 10 cycles.
- Interrupt, direct mode: mie_i=32'h0001_0000, mtvec_i=32'h100, irq_i[0]=1, ready_i=1 at cycle N → at N+1 trap_o=1, mcause_o=32'h8000_0010, irq_ack_o=1, redirect_pc_o=32'h100; in_handler_o=1 from N+2.
- Vectored mode with priority: mtvec_i=32'h101, irq_i[3] and irq_i[5] set, mie_i bits 19 and 21 set → mcause_o=32'h8000_0013, irq_ack_o[3]=1, redirect_pc_o=32'h100+4*19=32'h14C.
- Exception beats interrupt: exc_ecall_i=1 with irq_i[0] enabled → mcause_o=11, irq_ack_o=0, redirect_pc_o={mtvec_i[31:2],2'b00} (vectored mode ignored).
- Masking and return: in S_HANDLER, toggle irq_i for 20 cycles → no trap_o. Then mret_i=1 with mepc_i=32'h2004 → redirect_o with 32'h2004, in_handler_o=0. The still-pending irq is taken no earlier than 2 cycles after the mret sample.
- ready_i gating and reset mid-trap: irq_i=1 with ready_i=0 → no trap; trap_o follows the first ready_i=1 cycle by 1. Asserting rstn_i=0 during S_TRAP clears trap_o and redirect_o the next cycle.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Shared CSR-side constants and the trap sequencer state encoding.
package riscv_csr_pkg;

    localparam int MXLEN = 32;

    localparam logic [MXLEN-1:0] CAUSE_ILLEGAL = 'd2;
    localparam logic [MXLEN-1:0] CAUSE_EBREAK  = 'd3;
    localparam logic [MXLEN-1:0] CAUSE_ECALL   = 'd11;
    localparam int               CAUSE_IRQ_BASE = 16;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        S_RUN,
        S_TRAP,
        S_HANDLER,
        S_MRET
    } trap_state_e;

endpackage

// File: rtl/riscv_irq_prio.sv
// Lowest-index-wins priority encoder: valid flag, binary index and one-hot grant.
module riscv_irq_prio #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    assign valid_o  = |req_i;
    // Isolates the lowest set bit (two's-complement trick).
    assign onehot_o = req_i & (~req_i + 1'b1);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Trap/interrupt sequencer: picks exception or interrupt cause, pulses trap/redirect, handles mret.
module riscv_trap_ctrl
    import riscv_csr_pkg::*;
#(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               ready_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic               exc_illegal_i,
    input  logic               exc_ecall_i,
    input  logic               exc_ebreak_i,
    input  logic               mret_i,
    input  logic [MXLEN-1:0]   mie_i,
    input  logic [MXLEN-1:0]   mtvec_i,
    input  logic [MXLEN-1:0]   mepc_i,
    output logic               trap_o,
    output logic [MXLEN-1:0]   mcause_o,
    output logic               redirect_o,
    output logic [MXLEN-1:0]   redirect_pc_o,
    output logic [IRQ_NUM-1:0] irq_ack_o,
    output logic               in_handler_o
);

    localparam int IDX_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    trap_state_e        state_q, state_d;
    logic [MXLEN-1:0]   cause_q, cause_d;
    logic [IRQ_NUM-1:0] ack_q,   ack_d;

    logic [IRQ_NUM-1:0] irq_elig;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic [IRQ_NUM-1:0] irq_onehot;
    logic               exc_any;
    logic [MXLEN-1:0]   cause_sel;
    logic [IRQ_NUM-1:0] ack_sel;
    logic [MXLEN-1:0]   tvec_base;
    logic               unused_mie;

    // Only the platform-IRQ field of mie matters here; the rest is intentionally ignored.
    assign unused_mie = ^mie_i;

    assign irq_elig = irq_i & mie_i[CAUSE_IRQ_BASE +: IRQ_NUM] & {IRQ_NUM{~in_handler_o}};
    assign exc_any  = exc_ebreak_i | exc_illegal_i | exc_ecall_i;

    riscv_irq_prio #(
        .N     (IRQ_NUM),
        .IDX_W (IDX_W)
    ) u_irq_prio (
        .req_i    (irq_elig),
        .valid_o  (irq_valid),
        .idx_o    (irq_idx),
        .onehot_o (irq_onehot)
    );

    always_comb begin
        cause_sel = '0;
        ack_sel   = '0;
        if (exc_ebreak_i) begin
            cause_sel = CAUSE_EBREAK;
        end else if (exc_illegal_i) begin
            cause_sel = CAUSE_ILLEGAL;
        end else if (exc_ecall_i) begin
            cause_sel = CAUSE_ECALL;
        end else if (irq_valid) begin
            cause_sel = {1'b1, {(MXLEN-1){1'b0}}} | MXLEN'(CAUSE_IRQ_BASE + int'(irq_idx));
            ack_sel   = irq_onehot;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_d   = ack_q;
        case (state_q)
            S_RUN: begin
                if (ready_i && (exc_any || irq_valid)) begin
                    state_d = S_TRAP;
                    cause_d = cause_sel;
                    ack_d   = ack_sel;
                end else if (ready_i && mret_i) begin
                    state_d = S_MRET;
                end
            end
            S_TRAP: state_d = S_HANDLER;
            S_HANDLER: begin
                // A nested exception overwrites mepc; a double trap is unrecoverable by design.
                if (ready_i && exc_any) begin
                    state_d = S_TRAP;
                    cause_d = cause_sel;
                    ack_d   = '0;
                end else if (ready_i && mret_i) begin
                    state_d = S_MRET;
                end
            end
            S_MRET: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_RUN;
            cause_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ack_q   <= ack_d;
        end
    end

    assign tvec_base = {mtvec_i[MXLEN-1:2], 2'b00};

    always_comb begin
        trap_o        = 1'b0;
        redirect_o    = 1'b0;
        mcause_o      = '0;
        redirect_pc_o = '0;
        irq_ack_o     = '0;
        in_handler_o  = 1'b0;
        case (state_q)
            S_TRAP: begin
                trap_o     = 1'b1;
                redirect_o = 1'b1;
                mcause_o   = cause_q;
                irq_ack_o  = ack_q;
                if (mtvec_i[1:0] == MTVEC_MODE_VECTORED && cause_q[MXLEN-1]) begin
                    redirect_pc_o = tvec_base + {cause_q[MXLEN-3:0], 2'b00};
                end else begin
                    redirect_pc_o = tvec_base;
                end
            end
            S_HANDLER: in_handler_o = 1'b1;
            S_MRET: begin
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Directed self-checking bench for riscv_trap_ctrl with hand-computed expectations.
module tb_riscv_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ready_i;
    logic [15:0] irq_i;
    logic        exc_illegal_i, exc_ecall_i, exc_ebreak_i, mret_i;
    logic [31:0] mie_i, mtvec_i, mepc_i;
    logic        trap_o, redirect_o, in_handler_o;
    logic [31:0] mcause_o, redirect_pc_o;
    logic [15:0] irq_ack_o;

    int vectors     = 0;
    int miscompares = 0;

    riscv_trap_ctrl #(.IRQ_NUM(16)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .ready_i       (ready_i),
        .irq_i         (irq_i),
        .exc_illegal_i (exc_illegal_i),
        .exc_ecall_i   (exc_ecall_i),
        .exc_ebreak_i  (exc_ebreak_i),
        .mret_i        (mret_i),
        .mie_i         (mie_i),
        .mtvec_i       (mtvec_i),
        .mepc_i        (mepc_i),
        .trap_o        (trap_o),
        .mcause_o      (mcause_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .irq_ack_o     (irq_ack_o),
        .in_handler_o  (in_handler_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge and settle; inputs are changed and outputs read here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ready_i       = 1'b1;
        irq_i         = '0;
        exc_illegal_i = 1'b0;
        exc_ecall_i   = 1'b0;
        exc_ebreak_i  = 1'b0;
        mret_i        = 1'b0;
    endtask

    // Bundle of strobes {trap, redirect, in_handler} compared as one vector.
    function automatic logic [2:0] strobes();
        return {trap_o, redirect_o, in_handler_o};
    endfunction

    // Leave S_HANDLER through mret and settle back in S_RUN.
    task automatic leave_handler();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        mie_i   = '0;
        mtvec_i = '0;
        mepc_i  = '0;
        rstn_i  = 1'b0;
        repeat (3) tick();
        rstn_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({strobes(), mcause_o, redirect_pc_o, irq_ack_o} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: strobes=%b mcause=%h pc=%h ack=%h, want all 0",
                         c, strobes(), mcause_o, redirect_pc_o, irq_ack_o);
            end
            tick();
        end
    endtask

    task automatic test_irq_direct();
        clear_inputs();
        mie_i    = 32'h0001_0000;
        mtvec_i  = 32'h0000_0100;
        irq_i[0] = 1'b1;
        tick();
        irq_i = '0;
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'h8000_0010 || irq_ack_o !== 16'h0001 ||
            redirect_pc_o !== 32'h100) begin
            miscompares++;
            $display("FAIL irq_direct_trap: strobes=%b mcause=%h ack=%h pc=%h, want 110 80000010 0001 00000100",
                     strobes(), mcause_o, irq_ack_o, redirect_pc_o);
        end
        tick();
        vectors++;
        if (strobes() !== 3'b001 || mcause_o !== '0 || redirect_pc_o !== '0) begin
            miscompares++;
            $display("FAIL irq_direct_handler: strobes=%b mcause=%h pc=%h, want 001 0 0",
                     strobes(), mcause_o, redirect_pc_o);
        end
        mepc_i = 32'h0000_3000;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        vectors++;
        if (strobes() !== 3'b010 || redirect_pc_o !== 32'h3000) begin
            miscompares++;
            $display("FAIL irq_direct_mret: strobes=%b pc=%h, want 010 00003000", strobes(), redirect_pc_o);
        end
        tick();
        vectors++;
        if (strobes() !== 3'b000 || redirect_pc_o !== '0) begin
            miscompares++;
            $display("FAIL irq_direct_back_in_run: strobes=%b pc=%h, want 000 0", strobes(), redirect_pc_o);
        end
    endtask

    task automatic test_vectored_prio();
        clear_inputs();
        mtvec_i = 32'h0000_0101;
        mie_i   = (32'h1 << 19) | (32'h1 << 21);
        irq_i   = 16'h0028;
        tick();
        irq_i = '0;
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'h8000_0013 || irq_ack_o !== 16'h0008 ||
            redirect_pc_o !== 32'h14C) begin
            miscompares++;
            $display("FAIL vectored_prio: strobes=%b mcause=%h ack=%h pc=%h, want 110 80000013 0008 0000014c",
                     strobes(), mcause_o, irq_ack_o, redirect_pc_o);
        end
        tick();
        leave_handler();
    endtask

    // Exception plus mret plus enabled irq together: the exception wins; irq stays pending.
    task automatic test_exc_beats_irq();
        clear_inputs();
        mtvec_i     = 32'h0000_0101;
        mie_i       = 32'h0001_0000;
        irq_i[0]    = 1'b1;
        exc_ecall_i = 1'b1;
        mret_i      = 1'b1;
        tick();
        exc_ecall_i = 1'b0;
        mret_i      = 1'b0;
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'd11 || irq_ack_o !== '0 ||
            redirect_pc_o !== 32'h100) begin
            miscompares++;
            $display("FAIL exc_beats_irq: strobes=%b mcause=%h ack=%h pc=%h, want 110 0000000b 0000 00000100",
                     strobes(), mcause_o, irq_ack_o, redirect_pc_o);
        end
        tick();
    endtask

    // Runs from S_HANDLER left by test_exc_beats_irq.
    task automatic test_masking_return();
        int traps_seen;
        traps_seen = 0;
        for (int c = 0; c < 20; c++) begin
            irq_i[0] = c[0];
            irq_i[4] = ~c[0];
            tick();
            if (trap_o !== 1'b0 || in_handler_o !== 1'b1) traps_seen++;
        end
        vectors++;
        if (traps_seen !== 0) begin
            miscompares++;
            $display("FAIL masked_in_handler: %0d bad cycles, want 0", traps_seen);
        end
        irq_i    = 16'h0001;
        mepc_i   = 32'h0000_2004;
        mret_i   = 1'b1;
        tick();
        mret_i = 1'b0;
        vectors++;
        if (strobes() !== 3'b010 || redirect_pc_o !== 32'h2004) begin
            miscompares++;
            $display("FAIL mret_return: strobes=%b pc=%h, want 010 00002004", strobes(), redirect_pc_o);
        end
        tick();
        vectors++;
        if (trap_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_irq_too_early: trap=%b, want 0", trap_o);
        end
        tick();
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'h8000_0010 || redirect_pc_o !== 32'h140) begin
            miscompares++;
            $display("FAIL pending_irq_taken: strobes=%b mcause=%h pc=%h, want 110 80000010 00000140",
                     strobes(), mcause_o, redirect_pc_o);
        end
        irq_i = '0;
        tick();
        leave_handler();
    endtask

    task automatic test_exc_prio_nested();
        clear_inputs();
        mtvec_i       = 32'h0000_0201;
        exc_ebreak_i  = 1'b1;
        exc_illegal_i = 1'b1;
        exc_ecall_i   = 1'b1;
        tick();
        clear_inputs();
        vectors++;
        if (mcause_o !== 32'd3 || redirect_pc_o !== 32'h200 || trap_o !== 1'b1) begin
            miscompares++;
            $display("FAIL exc_priority: trap=%b mcause=%h pc=%h, want 1 00000003 00000200",
                     trap_o, mcause_o, redirect_pc_o);
        end
        tick();
        exc_illegal_i = 1'b1;
        exc_ecall_i   = 1'b1;
        tick();
        clear_inputs();
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'd2 || irq_ack_o !== '0) begin
            miscompares++;
            $display("FAIL nested_exc: strobes=%b mcause=%h ack=%h, want 110 00000002 0000",
                     strobes(), mcause_o, irq_ack_o);
        end
        tick();
        leave_handler();
    endtask

    task automatic test_mret_in_run();
        clear_inputs();
        mepc_i = 32'h0000_4008;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        vectors++;
        if (strobes() !== 3'b010 || redirect_pc_o !== 32'h4008 || mcause_o !== '0) begin
            miscompares++;
            $display("FAIL mret_in_run: strobes=%b pc=%h mcause=%h, want 010 00004008 0",
                     strobes(), redirect_pc_o, mcause_o);
        end
        tick();
        vectors++;
        if (strobes() !== 3'b000) begin
            miscompares++;
            $display("FAIL mret_in_run_after: strobes=%b, want 000", strobes());
        end
    endtask

    task automatic test_ready_gating_reset();
        int early;
        clear_inputs();
        mtvec_i  = 32'h0000_0100;
        mie_i    = 32'h0002_0000;
        irq_i[1] = 1'b1;
        ready_i  = 1'b0;
        early    = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (trap_o !== 1'b0 || redirect_o !== 1'b0) early++;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL ready_gating: %0d cycles trapped with ready_i=0, want 0", early);
        end
        ready_i = 1'b1;
        tick();
        vectors++;
        if (strobes() !== 3'b110 || mcause_o !== 32'h8000_0011 || irq_ack_o !== 16'h0002) begin
            miscompares++;
            $display("FAIL ready_first_trap: strobes=%b mcause=%h ack=%h, want 110 80000011 0002",
                     strobes(), mcause_o, irq_ack_o);
        end
        rstn_i = 1'b0;
        irq_i  = '0;
        tick();
        vectors++;
        if ({strobes(), mcause_o, redirect_pc_o, irq_ack_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_trap: strobes=%b mcause=%h pc=%h ack=%h, want all 0",
                     strobes(), mcause_o, redirect_pc_o, irq_ack_o);
        end
        rstn_i = 1'b1;
        tick();
        vectors++;
        if (strobes() !== 3'b000) begin
            miscompares++;
            $display("FAIL after_reset_mid_trap: strobes=%b, want 000", strobes());
        end
    endtask

    initial begin
        test_reset();
        test_irq_direct();
        test_vectored_prio();
        test_exc_beats_irq();
        test_masking_return();
        test_exc_prio_nested();
        test_mret_in_run();
        test_ready_gating_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
